dbg_hit_logger: RTL and testbench

//  Downstream consumer of the PC symbol-match stage. Captures each symbol hit (pc, 5-bit symbol id),

---
 rtl/dbg_pkg.sv | 38 +++
 rtl/dbg_sync_fifo.sv | 56 +++++
 rtl/dbg_hit_logger.sv | 153 +++++++++++++++
 tb/tb_dbg_hit_logger.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types and constants for the debug hit logger
// Contents: header magic and field positions, FIFO entry layout, output FSM states,
// header word builder.
package dbg_pkg;

  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_MAGIC_LSB = 24;
  localparam int         HDR_LOST_BIT  = 23;
  localparam int         HDR_SYM_LSB   = 16;
  localparam int         HDR_TS_LSB    = 0;

  // FIFO entry, MSB first: {lost, sym, ts, pc} = 1+5+16+32 bits
  typedef struct packed {
    logic        lost;
    logic [4:0]  sym;
    logic [15:0] ts;
    logic [31:0] pc;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PC   = 2'd2
  } state_e;

  function automatic logic [31:0] make_header(input entry_t e);
    logic [31:0] h;
    h                          = '0;
    h[HDR_MAGIC_LSB +: 8]      = HDR_MAGIC;
    h[HDR_LOST_BIT]            = e.lost;
    h[HDR_SYM_LSB +: 5]        = e.sym;
    h[HDR_TS_LSB +: 16]        = e.ts;
    return h;
  endfunction

endpackage

// File: rtl/dbg_sync_fifo.sv
// rtl/dbg_sync_fifo.sv - single-clock FIFO with registered level and look-ahead read
// Ports: clk, rst_n (async, active low); wr_en/wr_data push; rd_en pop;
// rd_data = head entry, rd_data_nxt = entry behind the head; level = occupancy 0..DEPTH.
module dbg_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 54
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         rd_data_nxt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Writes to a full FIFO and reads from an empty one are ignored
  assign wr_ok      = wr_en && (level != FULL);
  assign rd_ok      = rd_en && (level != '0);
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  assign rd_data     = mem[rd_ptr];
  assign rd_data_nxt = mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr_nxt;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dbg_hit_logger.sv
// rtl/dbg_hit_logger.sv - timestamps symbol hits, buffers them and emits two-word packets
// Ports: clk, rst_n (async, active low); hit_valid/hit_pc/hit_sym from the match stage;
// enable gates logging; clr_drop clears the drop counter and lost flag;
// m_valid/m_ready/m_data/m_last output word stream; drop_cnt overflow losses; fifo_lvl occupancy.
// Build option: HIT_DEDUP_EN suppresses a hit whose sym equals the last pushed sym.
module dbg_hit_logger
  import dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hit_valid,
  input  logic [31:0]            hit_pc,
  input  logic [4:0]             hit_sym,
  input  logic                   enable,
  input  logic                   clr_drop,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [31:0]            m_data,
  output logic                   m_last,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_lvl
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [TS_W-1:0] ts;
  logic            lost_pending;
  logic            dup;
  logic            accept;
  logic            full;
  logic            push;
  logic            drop;
  logic            pop;
  entry_t          wr_entry;
  entry_t          head;
  entry_t          head_nxt;
  state_e          state;

`ifdef HIT_DEDUP_EN
  logic [4:0] last_sym;
  logic       last_sym_vld;

  assign dup = last_sym_vld && (hit_sym == last_sym);

  // Only pushed hits update the memory; disabling logging forgets it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sym     <= '0;
      last_sym_vld <= 1'b0;
    end else if (!enable) begin
      last_sym_vld <= 1'b0;
    end else if (push) begin
      last_sym     <= hit_sym;
      last_sym_vld <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Fullness is judged on the registered level, so a same-cycle pop never makes room
  assign full   = (fifo_lvl == LW'(DEPTH));
  assign accept = hit_valid && enable && !dup;
  assign push   = accept && !full;
  assign drop   = accept && full;
  assign pop    = (state == ST_PC) && m_ready;

  assign wr_entry = '{lost: lost_pending, sym: hit_sym, ts: ts, pc: hit_pc};

  dbg_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (push),
    .wr_data     (wr_entry),
    .rd_en       (pop),
    .rd_data     (head),
    .rd_data_nxt (head_nxt),
    .level       (fifo_lvl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts           <= '0;
      drop_cnt     <= '0;
      lost_pending <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      // A drop coinciding with clr_drop is deliberately forgotten
      if (clr_drop) begin
        drop_cnt     <= '0;
        lost_pending <= 1'b0;
      end else if (drop) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        lost_pending <= 1'b1;
      end else if (push) begin
        lost_pending <= 1'b0;
      end
    end
  end

  // Output words are registered; the next header is taken from the entry behind
  // the head so consecutive packets follow without an idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_lvl != '0) begin
            state   <= ST_HDR;
            m_valid <= 1'b1;
            m_data  <= make_header(head);
            m_last  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (m_ready) begin
            state  <= ST_PC;
            m_data <= head.pc;
            m_last <= 1'b1;
          end
        end
        ST_PC: begin
          if (m_ready) begin
            m_last <= 1'b0;
            if (fifo_lvl > LW'(1)) begin
              state  <= ST_HDR;
              m_data <= make_header(head_nxt);
            end else begin
              state   <= ST_IDLE;
              m_valid <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_hit_logger.sv
// tb/tb_dbg_hit_logger.sv - directed self-checking bench for dbg_hit_logger
module tb_dbg_hit_logger;

  logic        clk;
  logic        rst_n;
  logic        hit_valid;
  logic [31:0] hit_pc;
  logic [4:0]  hit_sym;
  logic        enable;
  logic        clr_drop;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] drop_cnt;
  logic [4:0]  fifo_lvl;

  int          n_tests;
  int          n_fail;
  logic [15:0] tb_ts;
  logic [15:0] ts_arr [0:31];

  dbg_hit_logger #(.DEPTH(16), .TS_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit_valid (hit_valid),
    .hit_pc    (hit_pc),
    .hit_sym   (hit_sym),
    .enable    (enable),
    .clr_drop  (clr_drop),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .drop_cnt  (drop_cnt),
    .fifo_lvl  (fifo_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hdr(input logic lost, input logic [4:0] sym, input logic [15:0] ts);
    return {8'hA5, lost, 2'b00, sym, ts};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    tb_ts = tb_ts + 16'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hit_valid = 1'b0; hit_pc = '0; hit_sym = '0;
    enable = 1'b1; clr_drop = 1'b0; m_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    tb_ts = 16'd0;
  endtask

  task automatic send_hit(input logic [4:0] sym, input logic [31:0] pc, output logic [15:0] t);
    hit_valid = 1'b1; hit_sym = sym; hit_pc = pc;
    t = tb_ts;
    step();
    hit_valid = 1'b0;
  endtask

  // Accepts one output word within a cycle budget; leaves m_ready low afterwards
  task automatic get_word(output logic [31:0] d, output logic l, output bit ok);
    ok = 1'b0; d = '0; l = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (m_valid) begin
        d = m_data; l = m_last; ok = 1'b1;
      end
      step();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0 || drop_cnt !== 16'h0 || fifo_lvl !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h l=%b drop=%h lvl=%0d want 0 0 0 0 0", m_valid, m_data, m_last, drop_cnt, fifo_lvl);
    end
  endtask

  task automatic test_single_hit();
    logic [15:0] t;
    do_reset();
    for (int i = 0; i < 16; i++) step();
    m_ready = 1'b1;
    send_hit(5'd5, 32'h0000_0050, t);
    n_tests++;
    if (m_valid !== 1'b0 || fifo_lvl !== 5'd1) begin
      n_fail++; $display("FAIL single_cycle1: got v=%b lvl=%0d want v=0 lvl=1", m_valid, fifo_lvl);
    end
    step();
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'hA505_0010 || m_last !== 1'b0) begin
      n_fail++; $display("FAIL single_hdr: got v=%b d=%h l=%b want 1 a5050010 0", m_valid, m_data, m_last);
    end
    step();
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 32'h0000_0050 || m_last !== 1'b1) begin
      n_fail++; $display("FAIL single_pc: got v=%b d=%h l=%b want 1 00000050 1", m_valid, m_data, m_last);
    end
    step();
    n_tests++;
    if (m_valid !== 1'b0 || fifo_lvl !== 5'd0) begin
      n_fail++; $display("FAIL single_end: got v=%b lvl=%0d want 0 0", m_valid, fifo_lvl);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] t;
    logic [31:0] d;
    logic        l;
    bit          ok;
    m_ready = 1'b0;
    send_hit(5'd9, 32'hDEAD_BEEF, t);
    step();
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== hdr(1'b0, 5'd9, t) || m_last !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b want 1 %h 0", i, m_valid, m_data, m_last, hdr(1'b0, 5'd9, t));
      end
      step();
    end
    get_word(d, l, ok);
    n_tests++;
    if (!ok || d !== hdr(1'b0, 5'd9, t) || l !== 1'b0) begin
      n_fail++; $display("FAIL bp_hdr: got ok=%b d=%h l=%b want %h 0", ok, d, l, hdr(1'b0, 5'd9, t));
    end
    get_word(d, l, ok);
    n_tests++;
    if (!ok || d !== 32'hDEAD_BEEF || l !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_pc: got ok=%b d=%h l=%b v=%b want deadbeef 1 v=0", ok, d, l, m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] t0, t1;
    logic [31:0] exp_d [4];
    logic        exp_l [4];
    m_ready = 1'b0;
    send_hit(5'd1, 32'h0000_00A0, t0);
    send_hit(5'd2, 32'h0000_00B0, t1);
    step();
    exp_d[0] = hdr(1'b0, 5'd1, t0); exp_l[0] = 1'b0;
    exp_d[1] = 32'h0000_00A0;       exp_l[1] = 1'b1;
    exp_d[2] = hdr(1'b0, 5'd2, t1); exp_l[2] = 1'b0;
    exp_d[3] = 32'h0000_00B0;       exp_l[3] = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_last !== exp_l[i]) begin
        n_fail++; $display("FAIL b2b_word[%0d]: got v=%b d=%h l=%b want 1 %h %b", i, m_valid, m_data, m_last, exp_d[i], exp_l[i]);
      end
      step();
    end
    m_ready = 1'b0;
    n_tests++;
    if (m_valid !== 1'b0 || fifo_lvl !== 5'd0) begin
      n_fail++; $display("FAIL b2b_end: got v=%b lvl=%0d want 0 0", m_valid, fifo_lvl);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] t;
    logic [31:0] d;
    logic        l;
    bit          ok;
    logic [4:0]  s;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_hit(5'(i), 32'h100 + 32'(i), ts_arr[i]);
    step();
    n_tests++;
    if (fifo_lvl !== 5'd16 || drop_cnt !== 16'd4) begin
      n_fail++; $display("FAIL ovf_fill: got lvl=%0d drop=%0d want 16 4", fifo_lvl, drop_cnt);
    end
    get_word(d, l, ok);
    n_tests++;
    if (!ok || d !== hdr(1'b0, 5'd0, ts_arr[0])) begin
      n_fail++; $display("FAIL ovf_first_hdr: got ok=%b d=%h want %h", ok, d, hdr(1'b0, 5'd0, ts_arr[0]));
    end
    get_word(d, l, ok);
    n_tests++;
    if (!ok || d !== 32'h100 || fifo_lvl !== 5'd15) begin
      n_fail++; $display("FAIL ovf_first_pc: got ok=%b d=%h lvl=%0d want 00000100 15", ok, d, fifo_lvl);
    end
    send_hit(5'd20, 32'h200, ts_arr[20]);
    for (int k = 0; k < 16; k++) begin
      s = (k < 15) ? 5'(k + 1) : 5'd20;
      get_word(d, l, ok);
      n_tests++;
      if (!ok || d !== hdr(s == 5'd20, s, ts_arr[s]) || l !== 1'b0) begin
        n_fail++; $display("FAIL ovf_drain_hdr[%0d]: got ok=%b d=%h l=%b want %h 0", k, ok, d, l, hdr(s == 5'd20, s, ts_arr[s]));
      end
      get_word(d, l, ok);
      n_tests++;
      if (!ok || d !== ((s == 5'd20) ? 32'h200 : 32'h100 + 32'(s)) || l !== 1'b1) begin
        n_fail++; $display("FAIL ovf_drain_pc[%0d]: got ok=%b d=%h l=%b", k, ok, d, l);
      end
    end
    n_tests++;
    if (drop_cnt !== 16'd4 || fifo_lvl !== 5'd0) begin
      n_fail++; $display("FAIL ovf_after: got drop=%0d lvl=%0d want 4 0", drop_cnt, fifo_lvl);
    end
    clr_drop = 1'b1;
    step();
    clr_drop = 1'b0;
    n_tests++;
    if (drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clr_drop: got drop=%0d want 0", drop_cnt);
    end
    send_hit(5'd21, 32'h210, t);
    get_word(d, l, ok);
    n_tests++;
    if (!ok || d !== hdr(1'b0, 5'd21, t)) begin
      n_fail++; $display("FAIL ovf_lost_cleared: got ok=%b d=%h want %h", ok, d, hdr(1'b0, 5'd21, t));
    end
    get_word(d, l, ok);
  endtask

  task automatic test_enable_off();
    logic [15:0] t;
    enable = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_hit(5'(i + 10), 32'h400 + 32'(i), t);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (m_valid !== 1'b0 || fifo_lvl !== 5'd0 || drop_cnt !== 16'd0) begin
        n_fail++; $display("FAIL enable_off[%0d]: got v=%b lvl=%0d drop=%0d want 0 0 0", i, m_valid, fifo_lvl, drop_cnt);
      end
      step();
    end
    m_ready = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_dedup();
    logic [15:0] t [4];
    logic [4:0]  syms [4];
    logic [31:0] d;
    logic        l;
    bit          ok;
    int          n_exp;
    int          idx [4];
    syms[0] = 5'd3; syms[1] = 5'd3; syms[2] = 5'd3; syms[3] = 5'd7;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_hit(syms[i], 32'h300 + 32'(i), t[i]);
    step();
`ifdef HIT_DEDUP_EN
    n_exp = 2; idx[0] = 0; idx[1] = 3; idx[2] = 0; idx[3] = 0;
`else
    n_exp = 4; idx[0] = 0; idx[1] = 1; idx[2] = 2; idx[3] = 3;
`endif
    n_tests++;
    if (fifo_lvl !== 5'(n_exp)) begin
      n_fail++; $display("FAIL dedup_level: got %0d want %0d", fifo_lvl, n_exp);
    end
    for (int k = 0; k < n_exp; k++) begin
      get_word(d, l, ok);
      n_tests++;
      if (!ok || d !== hdr(1'b0, syms[idx[k]], t[idx[k]])) begin
        n_fail++; $display("FAIL dedup_hdr[%0d]: got ok=%b d=%h want %h", k, ok, d, hdr(1'b0, syms[idx[k]], t[idx[k]]));
      end
      get_word(d, l, ok);
      n_tests++;
      if (!ok || d !== 32'h300 + 32'(idx[k])) begin
        n_fail++; $display("FAIL dedup_pc[%0d]: got ok=%b d=%h want %h", k, ok, d, 32'h300 + 32'(idx[k]));
      end
    end
    step();
    n_tests++;
    if (m_valid !== 1'b0 || fifo_lvl !== 5'd0) begin
      n_fail++; $display("FAIL dedup_end: got v=%b lvl=%0d want 0 0", m_valid, fifo_lvl);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] t;
    logic [31:0] d;
    logic        l;
    bit          ok;
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_hit(5'(i), 32'h500 + 32'(i), t);
    step();
    n_tests++;
    if (drop_cnt !== 16'd1 || fifo_lvl !== 5'd16) begin
      n_fail++; $display("FAIL rst_pre_fill: got drop=%0d lvl=%0d want 1 16", drop_cnt, fifo_lvl);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_tests++;
    if (m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== 32'h500) begin
      n_fail++; $display("FAIL rst_pre_pc: got v=%b l=%b d=%h want 1 1 00000500", m_valid, m_last, m_data);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || fifo_lvl !== 5'd0 || drop_cnt !== 16'd0 || m_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got v=%b lvl=%0d drop=%0d l=%b want 0 0 0 0", m_valid, fifo_lvl, drop_cnt, m_last);
    end
    step();
    rst_n = 1'b1;
    tb_ts = 16'd0;
    send_hit(5'd6, 32'h600, t);
    get_word(d, l, ok);
    n_tests++;
    if (!ok || d !== 32'hA506_0000) begin
      n_fail++; $display("FAIL rst_ts_restart: got ok=%b d=%h want a5060000", ok, d);
    end
    get_word(d, l, ok);
    n_tests++;
    if (!ok || d !== 32'h600 || l !== 1'b1) begin
      n_fail++; $display("FAIL rst_after_pc: got ok=%b d=%h l=%b want 00000600 1", ok, d, l);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tb_ts   = 16'd0;
    test_reset();
    test_single_hit();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_enable_off();
    test_dedup();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
